// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM states and helper functions for the PS/2 key decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_REL        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;
  localparam int         PS2_FRAME_BITS = 11;
  localparam int         PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK
  } frameState_e;

  // Keyboard housekeeping replies (ACK, BAT, echo, overrun...) never map to a key.
  function automatic logic isIgnoredCode(input logic [7:0] code);
    case (code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic isOddParity(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 line, debounces it and flags filtered falling edges.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_stableCnt;
  logic             r_level;
  logic             r_fall;
  logic             w_differs;
  logic             w_accept;

  assign w_differs = (r_sync[1] != r_level);
  assign w_accept  = w_differs && (r_stableCnt == CNT_W'(FILTER_LEN - 1));

  // Lines idle high, so the filter starts high to avoid a spurious edge out of reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sync      <= 2'b11;
      r_stableCnt <= '0;
      r_level     <= 1'b1;
      r_fall      <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_fall <= w_accept && r_level;
      if (w_accept) begin
        r_level     <= r_sync[1];
        r_stableCnt <= '0;
      end else if (w_differs) begin
        r_stableCnt <= r_stableCnt + 1'b1;
      end else begin
        r_stableCnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames serial bytes, resolves E0/F0/E1 prefixes and
// publishes toggle-framed 11-bit key events.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 36000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ps2_clk,
  input  logic                      ps2_data,
  output logic [PS2_FRAME_BITS-1:0] ps2_key,
  output logic                      key_strobe,
  output logic                      frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic w_fall;
  logic w_data;
  logic w_unusedClkLevel;
  logic w_unusedDataFall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clkFilter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_line  (ps2_clk),
    .o_level (w_unusedClkLevel),
    .o_fall  (w_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dataFilter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_line  (ps2_data),
    .o_level (w_data),
    .o_fall  (w_unusedDataFall)
  );

  frameState_e               r_state,  w_nextState;
  logic [3:0]                r_bitCnt, w_nextBitCnt;
  logic [PS2_DATA_BITS-1:0]  r_shift,  w_nextShift;
  logic                      r_parity, w_nextParity;
  logic                      r_stop,   w_nextStop;
  logic [TO_W-1:0]           r_toCnt,  w_nextToCnt;
  logic                      r_ext,    w_nextExt;
  logic                      r_rel,    w_nextRel;
  logic [2:0]                r_skip,   w_nextSkip;
  logic [PS2_FRAME_BITS-1:0] r_key,    w_nextKey;
  logic                      r_strobe, w_nextStrobe;
  logic                      r_err,    w_nextErr;
  logic                      w_frameOk;

  assign w_frameOk = r_stop && isOddParity(r_shift, r_parity);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_stop   <= 1'b0;
      r_toCnt  <= '0;
      r_ext    <= 1'b0;
      r_rel    <= 1'b0;
      r_skip   <= '0;
      r_key    <= '0;
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_bitCnt <= w_nextBitCnt;
      r_shift  <= w_nextShift;
      r_parity <= w_nextParity;
      r_stop   <= w_nextStop;
      r_toCnt  <= w_nextToCnt;
      r_ext    <= w_nextExt;
      r_rel    <= w_nextRel;
      r_skip   <= w_nextSkip;
      r_key    <= w_nextKey;
      r_strobe <= w_nextStrobe;
      r_err    <= w_nextErr;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextBitCnt = r_bitCnt;
    w_nextShift  = r_shift;
    w_nextParity = r_parity;
    w_nextStop   = r_stop;
    w_nextToCnt  = r_toCnt;
    w_nextExt    = r_ext;
    w_nextRel    = r_rel;
    w_nextSkip   = r_skip;
    w_nextKey    = r_key;
    w_nextStrobe = 1'b0;
    w_nextErr    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_nextToCnt = '0;
        if (w_fall && !w_data) begin
          w_nextState  = ST_SHIFT;
          w_nextBitCnt = '0;
        end
      end

      // Bits 0-7 are data (LSB first), 8 is parity, 9 is the stop bit.
      ST_SHIFT: begin
        if (w_fall) begin
          w_nextToCnt  = '0;
          w_nextBitCnt = r_bitCnt + 4'd1;
          if (r_bitCnt < 4'd8) begin
            w_nextShift = {w_data, r_shift[PS2_DATA_BITS-1:1]};
          end else if (r_bitCnt == 4'd8) begin
            w_nextParity = w_data;
          end else begin
            w_nextStop  = w_data;
            w_nextState = ST_CHECK;
          end
        end else if (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_nextState = ST_IDLE;
          w_nextToCnt = '0;
          w_nextErr   = 1'b1;
          w_nextExt   = 1'b0;
          w_nextRel   = 1'b0;
          w_nextSkip  = '0;
        end else begin
          w_nextToCnt = r_toCnt + 1'b1;
        end
      end

      ST_CHECK: begin
        w_nextState = ST_IDLE;
        w_nextToCnt = '0;
        if (!w_frameOk) begin
          w_nextErr  = 1'b1;
          w_nextExt  = 1'b0;
          w_nextRel  = 1'b0;
          w_nextSkip = '0;
        end else if (r_skip != 3'd0) begin
          // Pause has no break code; the whole 8-byte burst becomes one press.
          w_nextSkip = r_skip - 3'd1;
          if (r_skip == 3'd1) begin
            w_nextKey    = {~r_key[PS2_FRAME_BITS-1], 1'b1, 1'b1, PS2_PAUSE_CODE};
            w_nextStrobe = 1'b1;
            w_nextExt    = 1'b0;
            w_nextRel    = 1'b0;
          end
        end else if (r_shift == PS2_PAUSE) begin
          w_nextSkip = PS2_PAUSE_SKIP;
        end else if (r_shift == PS2_EXT) begin
          w_nextExt = 1'b1;
        end else if (r_shift == PS2_REL) begin
          w_nextRel = 1'b1;
        end else if (isIgnoredCode(r_shift)) begin
          w_nextExt = 1'b0;
          w_nextRel = 1'b0;
        end else begin
          w_nextKey    = {~r_key[PS2_FRAME_BITS-1], ~r_rel, r_ext, r_shift};
          w_nextStrobe = 1'b1;
          w_nextExt    = 1'b0;
          w_nextRel    = 1'b0;
        end
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign ps2_key    = r_key;
  assign key_strobe = r_strobe;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks decoded key events.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 36000;
  localparam int HALF_BIT       = 20;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  int errorCount    = 0;
  int checkCount    = 0;
  int strobeCount   = 0;
  int errPulseCount = 0;
  int cycleCount    = 0;
  int lastFallCycle = 0;
  int errCycle      = 0;

  ps2_key_decoder #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_key    (ps2_key),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cycleCount++;

  // Count pulse-high cycles on the falling edge, well away from register updates.
  always @(negedge clk_sys) begin
    if (key_strobe) strobeCount++;
    if (frame_err) begin
      errPulseCount++;
      errCycle = cycleCount;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Sends the first nBits of a start/data/parity/stop frame, PS/2 clock held high between bits.
  task automatic applyStimulus(input logic [7:0] code, input logic parityFlip,
                               input logic stopBit, input int nBits);
    logic [10:0] frame;
    frame = {stopBit, (~^code) ^ parityFlip, code, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2_data = frame[i];
      waitCycles(HALF_BIT);
      ps2_clk       = 1'b0;
      lastFallCycle = cycleCount;
      waitCycles(HALF_BIT);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    waitCycles(4 * HALF_BIT);
  endtask

  initial begin
    int s0;
    int e0;
    int delta;

    reset = 1'b1;
    waitCycles(3);
    checkOutput("reset_key", ps2_key, 11'd0);
    checkOutput("reset_strobe", key_strobe, 1'b0);
    checkOutput("reset_err", frame_err, 1'b0);
    reset = 1'b0;
    waitCycles(20);

    // Scenario 1: plain make code
    s0 = strobeCount; e0 = errPulseCount;
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkOutput("t1_key", ps2_key, 11'b1_1_0_00011100);
    checkOutput("t1_strobes", strobeCount - s0, 1);
    checkOutput("t1_errs", errPulseCount - e0, 0);

    // Scenario 2: break code
    s0 = strobeCount;
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    checkOutput("t2_no_event_f0", strobeCount - s0, 0);
    checkOutput("t2_key_held", ps2_key, 11'b1_1_0_00011100);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkOutput("t2_key", ps2_key, 11'b0_0_0_00011100);
    checkOutput("t2_strobes", strobeCount - s0, 1);

    // Scenario 3: extended make and break
    s0 = strobeCount;
    applyStimulus(8'hE0, 1'b0, 1'b1, 11);
    applyStimulus(8'h75, 1'b0, 1'b1, 11);
    checkOutput("t3_ext_make", ps2_key, 11'b1_1_1_01110101);
    applyStimulus(8'hE0, 1'b0, 1'b1, 11);
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    applyStimulus(8'h75, 1'b0, 1'b1, 11);
    checkOutput("t3_ext_break", ps2_key, 11'b0_0_1_01110101);
    checkOutput("t3_strobes", strobeCount - s0, 2);

    // Scenario 4: parity and stop errors clear the prefix flags
    s0 = strobeCount; e0 = errPulseCount;
    applyStimulus(8'h29, 1'b1, 1'b1, 11);
    checkOutput("t4_parity_err", errPulseCount - e0, 1);
    checkOutput("t4_key_held", ps2_key, 11'b0_0_1_01110101);
    applyStimulus(8'hE0, 1'b0, 1'b0, 11);
    checkOutput("t4_stop_err", errPulseCount - e0, 2);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    checkOutput("t4_key", ps2_key, 11'b1_1_0_00101001);
    checkOutput("t4_strobes", strobeCount - s0, 1);

    // Scenario 5: timeout on a partial frame, then recovery
    e0 = errPulseCount;
    applyStimulus(8'h1C, 1'b0, 1'b1, 5);
    checkOutput("t5_no_early_err", errPulseCount - e0, 0);
    for (int i = 0; i < TIMEOUT_CYCLES + 200 && errPulseCount == e0; i++) waitCycles(1);
    checkOutput("t5_timeout_err", errPulseCount - e0, 1);
    delta = errCycle - lastFallCycle;
    checkOutput("t5_timeout_window", (delta >= TIMEOUT_CYCLES) && (delta <= TIMEOUT_CYCLES + 30), 1'b1);
    checkOutput("t5_key_held", ps2_key, 11'b1_1_0_00101001);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkOutput("t5_recover_key", ps2_key, 11'b0_1_0_00011100);

    // Reset in the middle of a frame
    applyStimulus(8'h1C, 1'b0, 1'b1, 6);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("t5_rst_key", ps2_key, 11'd0);
    checkOutput("t5_rst_strobe", key_strobe, 1'b0);
    checkOutput("t5_rst_err", frame_err, 1'b0);
    reset = 1'b0;
    waitCycles(20);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkOutput("t5_post_rst_key", ps2_key, 11'b1_1_0_00011100);

    // Scenario 6: short clock glitch with data low must not start a frame
    s0 = strobeCount; e0 = errPulseCount;
    ps2_data = 1'b0;
    waitCycles(5);
    ps2_clk = 1'b0;
    waitCycles(3);
    ps2_clk = 1'b1;
    waitCycles(40);
    ps2_data = 1'b1;
    waitCycles(40);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkOutput("t6_glitch_key", ps2_key, 11'b0_1_0_00011100);
    checkOutput("t6_glitch_errs", errPulseCount - e0, 0);
    checkOutput("t6_glitch_strobes", strobeCount - s0, 1);

    // Pause burst yields exactly one extended press of 0x77
    s0 = strobeCount;
    applyStimulus(8'hE1, 1'b0, 1'b1, 11);
    applyStimulus(8'h14, 1'b0, 1'b1, 11);
    applyStimulus(8'h77, 1'b0, 1'b1, 11);
    applyStimulus(8'hE1, 1'b0, 1'b1, 11);
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    applyStimulus(8'h14, 1'b0, 1'b1, 11);
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    checkOutput("t6_pause_pending", strobeCount - s0, 0);
    applyStimulus(8'h77, 1'b0, 1'b1, 11);
    checkOutput("t6_pause_key", ps2_key, 11'b1_1_1_01110111);
    checkOutput("t6_pause_strobes", strobeCount - s0, 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
